writeback_arb: RTL and testbench

//  Writeback arbiter feeding the register file's single write port (w_reg/w_dat/write).

---
 rtl/writeback_arb_pkg.sv | 14 +
 rtl/writeback_arb_if.sv | 29 ++
 rtl/writeback_arb_fifo.sv | 66 ++++++
 rtl/writeback_arb.sv | 85 ++++++++
 tb/tb_writeback_arb.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/writeback_arb_pkg.sv
// Shared types for the writeback arbiter: result entry layout and rd one-hot decode.
package wb_pkg;
  localparam int XLEN_DEF   = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN_DEF-1:0]   dat;
  } wb_entry_t;

  function automatic logic [31:0] onehot_rd(input logic [REG_ADDR_W-1:0] rd);
    onehot_rd = 32'd1 << rd;
  endfunction
endpackage

// File: rtl/writeback_arb_if.sv
// Writeback bundle: ALU result, LSU valid/ready result, register-file write port and hazard status.
interface writeback_arb_if
  import wb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = 4
) ();
  logic                    alu_valid;
  logic [REG_ADDR_W-1:0]   alu_rd;
  logic [XLEN-1:0]         alu_dat;
  logic                    lsu_valid;
  logic                    lsu_ready;
  logic [REG_ADDR_W-1:0]   lsu_rd;
  logic [XLEN-1:0]         lsu_dat;
  logic                    write;
  logic [REG_ADDR_W-1:0]   w_reg;
  logic [XLEN-1:0]         w_dat;
  logic [31:0]             pending_mask;
  logic [$clog2(DEPTH):0]  fifo_count;

  modport master (
    output alu_valid, alu_rd, alu_dat, lsu_valid, lsu_rd, lsu_dat,
    input  lsu_ready, write, w_reg, w_dat, pending_mask, fifo_count
  );
  modport slave (
    input  alu_valid, alu_rd, alu_dat, lsu_valid, lsu_rd, lsu_dat,
    output lsu_ready, write, w_reg, w_dat, pending_mask, fifo_count
  );
endinterface

// File: rtl/writeback_arb_fifo.sv
// LSU result FIFO with per-entry valid bits so the pending-rd mask is a plain OR over live entries.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  wb_entry_t              i_dat,
  input  logic                   i_pop,
  output wb_entry_t              o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [31:0]            o_mask
);
  localparam int PW = $clog2(DEPTH);

  wb_entry_t          r_mem [DEPTH];
  logic [DEPTH-1:0]   r_vld;
  logic [PW-1:0]      r_wp;
  logic [PW-1:0]      r_rp;
  logic [PW:0]        r_cnt;
  logic               w_pop;
  logic [31:0]        w_mask;

  assign o_full  = (r_cnt == (PW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_vld[r_wp] <= 1'b1;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_vld[r_rp] <= 1'b0;
        r_rp        <= r_rp + 1'b1;
      end
      r_cnt <= r_cnt + (PW+1)'(i_push) - (PW+1)'(w_pop);
    end
  end

  // Payload needs no reset: r_vld gates every consumer.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp] <= i_dat;
  end

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i]) w_mask = w_mask | onehot_rd(r_mem[i].rd);
    end
  end

  assign o_head  = r_mem[r_rp];
  assign o_count = r_cnt;
  assign o_mask  = w_mask & ~32'd1;
endmodule

// File: rtl/writeback_arb.sv
// Register-file write-port arbiter: ALU always wins, LSU results queue in wb_fifo and drain in ALU-idle cycles.
// Optional WB_LSU_BYPASS_EN lets an LSU result skip the empty FIFO for 1-cycle latency.
module writeback_arb
  import wb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  writeback_arb_if.slave  bus
);
  logic                   r_write;
  logic [REG_ADDR_W-1:0]  r_reg;
  logic [XLEN-1:0]        r_dat;

  logic                   w_alu_win;
  logic                   w_accept;
  logic                   w_byp;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  wb_entry_t              w_lsu_ent;
  wb_entry_t              w_head;
  logic [$clog2(DEPTH):0] w_count;
  logic [31:0]            w_mask;

  assign w_alu_win     = bus.alu_valid && (bus.alu_rd != '0);
  // No pop credit: a full FIFO refuses even when it drains this cycle.
  assign bus.lsu_ready = !rst && !w_full;
  assign w_accept      = bus.lsu_valid && bus.lsu_ready && (bus.lsu_rd != '0);
  assign w_lsu_ent.rd  = bus.lsu_rd;
  assign w_lsu_ent.dat = bus.lsu_dat;

`ifdef WB_LSU_BYPASS_EN
  assign w_byp = w_accept && w_empty && !w_alu_win;
`else
  assign w_byp = 1'b0;
`endif

  assign w_push = w_accept && !w_byp;
  assign w_pop  = !w_alu_win && !w_empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_dat   (w_lsu_ent),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_mask  (w_mask)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write <= 1'b0;
      r_reg   <= '0;
      r_dat   <= '0;
    end else if (w_alu_win) begin
      r_write <= 1'b1;
      r_reg   <= bus.alu_rd;
      r_dat   <= bus.alu_dat;
    end else if (w_pop) begin
      r_write <= 1'b1;
      r_reg   <= w_head.rd;
      r_dat   <= w_head.dat;
    end else if (w_byp) begin
      r_write <= 1'b1;
      r_reg   <= bus.lsu_rd;
      r_dat   <= bus.lsu_dat;
    end else begin
      r_write <= 1'b0;
    end
  end

  assign bus.write        = r_write;
  assign bus.w_reg        = r_reg;
  assign bus.w_dat        = r_dat;
  assign bus.pending_mask = w_mask;
  assign bus.fifo_count   = w_count;
endmodule

// File: tb/tb_writeback_arb.sv
// Bench for writeback_arb: queue-based reference model checked every cycle, directed scenarios plus random traffic.
module tb_writeback_arb;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  writeback_arb_if #(.XLEN(32), .DEPTH(DEPTH)) bus ();

  writeback_arb #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference state: queued LSU results as {rd,dat}, plus the expected output register.
  logic [36:0] q[$];
  logic        e_wr  = 1'b0;
  logic [4:0]  e_reg = '0;
  logic [31:0] e_dat = '0;
  bit          acc_last;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (q[i]) m = m | (32'd1 << q[i][36:32]);
    return m;
  endfunction

  task automatic compare_all();
    chk("write", bus.write, e_wr);
    chk("w_reg", bus.w_reg, e_reg);
    chk("w_dat", bus.w_dat, e_dat);
    chk("fifo_count", bus.fifo_count, q.size());
    chk("pending_mask", bus.pending_mask, model_mask());
  endtask

  task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
    bit acc;
    bit byp;
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_dat   = adat;
    bus.lsu_valid = lv;
    bus.lsu_rd    = lrd;
    bus.lsu_dat   = ldat;
    #1;
    chk("lsu_ready", bus.lsu_ready, q.size() != DEPTH);
    acc = lv && (q.size() != DEPTH);
    byp = 1'b0;
    if (av && ard != 0) begin
      e_wr = 1'b1; e_reg = ard; e_dat = adat;
    end else if (q.size() != 0) begin
      {e_reg, e_dat} = q.pop_front();
      e_wr = 1'b1;
    end
`ifdef WB_LSU_BYPASS_EN
    else if (acc && lrd != 0) begin
      e_wr = 1'b1; e_reg = lrd; e_dat = ldat; byp = 1'b1;
    end
`endif
    else begin
      e_wr = 1'b0;
    end
    if (acc && lrd != 0 && !byp) q.push_back({lrd, ldat});
    acc_last = acc;
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int k;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_dat = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_dat = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.lsu_ready, 1'b0);
    compare_all();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", bus.lsu_ready, 1'b1);
    @(negedge clk);

    // ALU only
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    chk("alu_write", bus.write, 1'b1);
    chk("alu_reg", bus.w_reg, 5'd5);
    chk("alu_dat", bus.w_dat, 32'hDEADBEEF);

    // rd=0 on both sources
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55);
    chk("rd0_lsu_count", bus.fifo_count, 0);
    chk("rd0_lsu_write", bus.write, 1'b0);
    cycle(1'b1, 5'd0, 32'h66, 1'b0, 5'd0, 32'h0);
    chk("rd0_alu_write", bus.write, 1'b0);

    // Empty-FIFO LSU result latency
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12);
`ifdef WB_LSU_BYPASS_EN
    chk("byp_write", bus.write, 1'b1);
    chk("byp_reg", bus.w_reg, 5'd7);
    chk("byp_mask", bus.pending_mask, 32'h0);
`else
    chk("nobyp_write0", bus.write, 1'b0);
    chk("nobyp_mask", bus.pending_mask, 32'h80);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("nobyp_write1", bus.write, 1'b1);
    chk("nobyp_reg", bus.w_reg, 5'd7);
    chk("nobyp_mask_clr", bus.pending_mask, 32'h0);
`endif

    // Contention: ALU busy 6 cycles while LSU offers rd1..5
    k = 1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 5'd20, 32'(i), k <= 5, 5'(k), 32'(100 + k));
      if (acc_last) k++;
    end
    chk("cont_ready", bus.lsu_ready, 1'b0);
    chk("cont_mask", bus.pending_mask, 32'h1E);
    chk("cont_count", bus.fifo_count, 4);
    for (int j = 1; j <= 5; j++) begin
      cycle(1'b0, 5'd0, 32'h0, k <= 5, 5'(k), 32'(100 + k));
      if (acc_last) k++;
      chk("cont_order", bus.w_reg, 5'(j));
      chk("cont_wdat", bus.w_dat, 32'(100 + j));
    end

    // Push and pop together at count=2
    cycle(1'b1, 5'd9, 32'h1, 1'b1, 5'd11, 32'hB);
    cycle(1'b1, 5'd9, 32'h2, 1'b1, 5'd12, 32'hC);
    chk("pp_count_pre", bus.fifo_count, 2);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'hD);
    chk("pp_count", bus.fifo_count, 2);
    chk("pp_reg0", bus.w_reg, 5'd11);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("pp_reg1", bus.w_reg, 5'd12);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("pp_reg2", bus.w_reg, 5'd13);
    chk("pp_count_end", bus.fifo_count, 0);

    // Reset mid-stream with 3 entries queued
    cycle(1'b1, 5'd2, 32'h1, 1'b1, 5'd3, 32'h3);
    cycle(1'b1, 5'd2, 32'h2, 1'b1, 5'd4, 32'h4);
    cycle(1'b1, 5'd2, 32'h3, 1'b1, 5'd6, 32'h6);
    chk("mid_count_pre", bus.fifo_count, 3);
    bus.alu_valid = 1'b0;
    bus.lsu_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_write", bus.write, 1'b0);
    chk("mid_rst_count", bus.fifo_count, 0);
    chk("mid_rst_mask", bus.pending_mask, 32'h0);
    chk("mid_rst_ready", bus.lsu_ready, 1'b0);
    q.delete();
    e_wr = 1'b0; e_reg = '0; e_dat = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rel_ready", bus.lsu_ready, 1'b1);
    @(negedge clk);
    compare_all();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) < 40, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 99) < 60, 5'($urandom_range(0, 31)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
